// File: rtl/sbm_result_unloader.sv
// sbm_result_unloader: captures a full multiplier product in one cycle and
// streams it out as WORD-bit words over a valid/ready interface.
// Optional build macro: SBM_UNLOAD_MSW_FIRST_EN (most-significant word first).
`timescale 1ns/1ps
module sbm_result_unloader #(
  parameter int SIZEC = 1142,
  parameter int WORD  = 64,
  parameter int WORDS = 18,
  parameter int IDXW  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SIZEC-1:0] prod,
  input  logic             prod_valid,
  output logic             prod_ready,
  output logic [WORD-1:0]  out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last,
  output logic             busy
);

  localparam int CAPW = WORDS * WORD;

`ifdef SBM_UNLOAD_MSW_FIRST_EN
  localparam logic [IDXW-1:0] IDX_FIRST = IDXW'(WORDS - 1);
  localparam logic [IDXW-1:0] IDX_LAST  = '0;
`else
  localparam logic [IDXW-1:0] IDX_FIRST = '0;
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(WORDS - 1);
`endif

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  state_t                     state, state_n;
  logic [IDXW-1:0]            cnt, cnt_n;
  logic                       load;
  // Capture is padded to a whole number of words; pad bits are always zero.
  logic [WORDS-1:0][WORD-1:0] cap;

  // State, counter and capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      cap   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (load) cap <= CAPW'(prod);
    end
  end

  // Next-state: capture in idle, step the word counter on each transfer.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (prod_valid) begin
          load    = 1'b1;
          cnt_n   = IDX_FIRST;
          state_n = ST_SEND;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          if (cnt == IDX_LAST) begin
            cnt_n   = '0;
            state_n = ST_IDLE;
          end else begin
`ifdef SBM_UNLOAD_MSW_FIRST_EN
            cnt_n = cnt - IDXW'(1);
`else
            cnt_n = cnt + IDXW'(1);
`endif
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Outputs: word path is zeroed whenever no word is being presented.
  always_comb begin
    prod_ready = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_idx    = '0;
    out_last   = 1'b0;
    if (state == ST_IDLE) begin
      prod_ready = !rst;
    end else begin
      busy      = 1'b1;
      out_valid = 1'b1;
      out_data  = cap[cnt];
      out_idx   = cnt;
      out_last  = (cnt == IDX_LAST);
    end
  end

endmodule

// File: tb/tb_sbm_result_unloader.sv
// Scoreboard bench for sbm_result_unloader. Honours SBM_UNLOAD_MSW_FIRST_EN.
`timescale 1ns/1ps
module tb_sbm_result_unloader;
  localparam int SIZEC = 1142;
  localparam int WORD  = 64;
  localparam int WORDS = 18;
  localparam int IDXW  = 5;
  localparam int CAPW  = WORDS * WORD;
`ifdef SBM_UNLOAD_MSW_FIRST_EN
  localparam bit MSW = 1'b1;
`else
  localparam bit MSW = 1'b0;
`endif
  localparam int FIRST_POS = MSW ? WORDS - 1 : 0;

  logic             clk = 1'b0;
  logic             rst;
  logic [SIZEC-1:0] prod;
  logic             prod_valid;
  logic             prod_ready;
  logic [WORD-1:0]  out_data;
  logic             out_valid;
  logic             out_ready;
  logic [IDXW-1:0]  out_idx;
  logic             out_last;
  logic             busy;

  typedef struct packed {
    logic [IDXW-1:0] idx;
    logic [WORD-1:0] data;
    logic            last;
    logic            first;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   rmode = 0;
  int   rk = 0;
  int   last_xfer_cyc = -100;
  int   gap = -1;

  sbm_result_unloader #(
    .SIZEC(SIZEC),
    .WORD (WORD),
    .WORDS(WORDS),
    .IDXW (IDXW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .prod      (prod),
    .prod_valid(prod_valid),
    .prod_ready(prod_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Consumer backpressure: 0 always ready, 1 pattern 1,0,0,1, 2 random, 3 stalled.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rk++;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (rk % 4 == 0) || (rk % 4 == 3);
        2:       out_ready = ($urandom_range(0, 9) < 7);
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [WORD-1:0] act, input logic [WORD-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: word k is simply bits [64k+63:64k] of the zero-extended product.
  function automatic logic [WORD-1:0] word_of(input logic [SIZEC-1:0] p, input int k);
    logic [CAPW-1:0] t;
    t = CAPW'(p) >> (k * WORD);
    return t[WORD-1:0];
  endfunction

  function automatic logic [SIZEC-1:0] rand_prod();
    logic [SIZEC-1:0] p;
    p = '0;
    for (int j = 0; j < 36; j++) p = {p[SIZEC-33:0], $urandom()};
    return p;
  endfunction

  task automatic push_product(input logic [SIZEC-1:0] p);
    exp_t e;
    for (int i = 0; i < WORDS; i++) begin
      int k;
      k = MSW ? WORDS - 1 - i : i;
      e.idx   = IDXW'(k);
      e.data  = word_of(p, k);
      e.last  = (i == WORDS - 1);
      e.first = (i == 0);
      sb.push_back(e);
    end
  endtask

  // Offer a product and hold it until the unloader takes it.
  task automatic send(input logic [SIZEC-1:0] p);
    int n;
    push_product(p);
    @(posedge clk);
    #1;
    prod       = p;
    prod_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!prod_ready && n < 500);
    if (!prod_ready) begin
      tests++;
      fails++;
      $display("FAIL capture_timeout: prod_ready never rose, required 1");
    end
    @(posedge clk);
    #1;
    prod_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(sb.size() == 0 && !out_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || out_valid) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d words outstanding, required 0", sb.size());
    end
  endtask

  task automatic wait_last_xfer();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_ready && out_last) && n < 500);
    if (!(out_valid && out_ready && out_last)) begin
      tests++;
      fails++;
      $display("FAIL last_timeout: no last transfer seen, required one");
    end
  endtask

  // Monitor: pops the scoreboard on every transfer, checks holds and idle zeroing.
  initial begin
    logic hold;
    exp_t held;
    exp_t e;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        sb.delete();
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_valid", WORD'(out_valid), WORD'(1'b1));
          chk("hold_data", out_data, held.data);
          chk("hold_idx", WORD'(out_idx), WORD'(held.idx));
          chk("hold_last", WORD'(out_last), WORD'(held.last));
        end
        hold = 1'b0;
        if (!out_valid) begin
          chk("idle_data_zero", out_data, '0);
        end else if (out_ready) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_word: got idx %0d data %h, required no word", out_idx, out_data);
          end else begin
            e = sb.pop_front();
            chk("word_idx", WORD'(out_idx), WORD'(e.idx));
            chk("word_data", out_data, e.data);
            chk("word_last", WORD'(out_last), WORD'(e.last));
            if (e.first) gap = cyc - last_xfer_cyc;
            if (e.last) last_xfer_cyc = cyc;
          end
        end else begin
          hold      = 1'b1;
          held.idx  = out_idx;
          held.data = out_data;
          held.last = out_last;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SIZEC-1:0] p;
    int n;
    rst        = 1'b1;
    prod       = '0;
    prod_valid = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("reset_prod_ready", WORD'(prod_ready), '0);
    chk("reset_out_valid", WORD'(out_valid), '0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_prod_ready", WORD'(prod_ready), WORD'(1'b1));
    chk("idle_out_valid", WORD'(out_valid), '0);
    chk("idle_out_data", out_data, '0);
    chk("idle_out_idx", WORD'(out_idx), '0);
    chk("idle_out_last", WORD'(out_last), '0);
    chk("idle_busy", WORD'(busy), '0);

    // Single set bit, full-rate consumer: latency and ready-after-last.
    rmode = 0;
    p = '0;
    p[0] = 1'b1;
    send(p);
    @(negedge clk);
    chk("first_word_latency", WORD'(out_valid), WORD'(1'b1));
    chk("first_word_idx", WORD'(out_idx), WORD'(FIRST_POS));
    chk("busy_while_send", WORD'(busy), WORD'(1'b1));
    chk("not_ready_while_send", WORD'(prod_ready), '0);
    wait_last_xfer();
    @(negedge clk);
    chk("ready_after_last", WORD'(prod_ready), WORD'(1'b1));
    chk("idle_after_last", WORD'(out_valid), '0);
    drain();

    // All ones: top word carries only 54 valid bits.
    p = '1;
    send(p);
    drain();
    chk("top_word_padding", word_of(p, WORDS - 1), 64'h003F_FFFF_FFFF_FFFF);

    // Word k = k under a 1,0,0,1 consumer.
    p = '0;
    for (int k = 0; k < WORDS; k++) p = p | (SIZEC'(k) << (k * WORD));
    rmode = 1;
    send(p);
    drain();
    rmode = 0;

    // P2 held valid during P1's drain.
    send(rand_prod());
    send(rand_prod());
    drain();
    chk("p2_gap_after_p1_last", WORD'(gap), WORD'(2));

    // Reset one cycle after the sixth word transfers.
    send(rand_prod());
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_ready && out_idx == IDXW'(MSW ? 12 : 5)) && n < 200);
    chk("reached_word5", WORD'(out_idx), WORD'(MSW ? 12 : 5));
    rmode = 3;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    rmode = 0;
    @(negedge clk);
    chk("rst_drops_valid", WORD'(out_valid), '0);
    chk("rst_drops_busy", WORD'(busy), '0);
    @(negedge clk);
    chk("no_resume_after_rst", WORD'(out_valid), '0);
    p = SIZEC'(16'hABCD);
    send(p);
    @(negedge clk);
    chk("post_rst_first_idx", WORD'(out_idx), WORD'(FIRST_POS));
    chk("post_rst_first_data", out_data, word_of(p, FIRST_POS));
    drain();

    // Top product bit only.
    p = '0;
    p[SIZEC-1] = 1'b1;
    send(p);
    @(negedge clk);
    chk("msb_first_data", out_data, MSW ? 64'h0020_0000_0000_0000 : 64'h0);
    drain();

    // Random products, random consumer, random gaps.
    rmode = 2;
    for (int t = 0; t < 25; t++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(rand_prod());
    end
    drain();
    rmode = 0;

    chk("scoreboard_empty", WORD'(sb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sbm_result_unloader.md
Name: sbm_result_unloader

Overview:
Downstream stage of the sbm_digitized multiplier. Captures the full 1142-bit product in one cycle and streams it out as fixed-width words over a valid/ready interface toward the bus or memory side. It frees the multiplier as soon as the product is captured, so the multiplier can start the next operation while the words drain.

Parameters:
SIZEC, 1142, product width in bits (SIZEA+SIZEB)
WORD, 64, output word width in bits
WORDS, 18, number of output words, ceil(SIZEC/WORD)
IDXW, 5, width of the word index, ceil(log2(WORDS))

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous, active-high reset
prod  input  SIZEC  product from the multiplier
prod_valid  input  1  product on prod is final
prod_ready  output  1  unloader can capture this cycle
out_data  output  WORD  current output word
out_valid  output  1  out_data is valid
out_ready  input  1  consumer accepts the word
out_idx  output  IDXW  index of the current word
out_last  output  1  current word is the final word of the product
busy  output  1  a product is captured and not fully drained

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high, sampled on posedge clk.
- Reset values: prod_ready=0 during the reset cycle, then 1 in ST_IDLE. out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0. Capture register and word counter are cleared.
- FSM states: ST_IDLE, ST_SEND.
- ST_IDLE:
  - prod_ready=1.
  - When prod_valid=1: capture prod into a SIZEC-bit register, set counter=0, go to ST_SEND.
  - out_valid is high on the next cycle, so latency from capture to first word is 1 cycle.
- ST_SEND:
  - prod_ready=0, busy=1, out_valid=1.
  - out_data = capture[counter*WORD +: WORD]. Bits at or above SIZEC read as 0, so the top word carries 54 valid bits and bits 63:54 are 0.
  - out_idx = counter.
  - out_last = 1 when counter == WORDS-1.
- Word handshake:
  - A word transfers on a cycle with out_valid & out_ready.
  - On transfer, counter increments.
  - While out_valid=1 and out_ready=0, out_data, out_idx and out_last hold stable.
  - When the last word transfers, go to ST_IDLE. prod_ready=1 on the following cycle.
  - Minimum period per product is WORDS+1 cycles (one capture cycle plus 18 words).
- out_data = 0 whenever out_valid=0.
- prod_valid while busy: ignored, not captured, no error. The producer must hold prod and prod_valid until it sees prod_ready=1.
- Simultaneous events: prod_valid in the same cycle as the last-word transfer is not captured that cycle. It is captured on the next cycle if still asserted.
- Reset mid-stream: immediate return to ST_IDLE. Remaining words are discarded, out_valid drops the cycle after rst is sampled, and nothing resumes after reset.
- Counter wrap: the counter never exceeds WORDS-1. No modulo wrap inside a product.

Optional Feature:
- Macro: SBM_UNLOAD_MSW_FIRST_EN.
- Defined: words are sent most-significant first.
  - Counter starts at WORDS-1 and decrements on each transfer.
  - out_idx reports the true word position (17 down to 0).
  - out_last = 1 when out_idx == 0.
  - First word is the zero-padded top word.
- Undefined: least-significant first.
  - out_idx counts 0 to 17.
  - out_last at out_idx 17.
- All other timing is identical in both modes.

Test Plan:
- prod=1, prod_valid pulse, out_ready=1 constant -> 18 consecutive words: idx0 data 0x1, idx1..17 data 0. out_last only at idx17. prod_ready high again 1 cycle after the idx17 transfer.
- prod=2^1142-1, out_ready=1 -> words 0..16 = 0xFFFF_FFFF_FFFF_FFFF, word17 = 0x003F_FFFF_FFFF_FFFF.
- prod = word k holds value k (k=0..17), out_ready toggling 1,0,0,1,… -> each word held stable while out_ready=0. Every word is seen exactly once in order 0..17 with matching data.
- Capture P1, then hold prod_valid=1 with P2 during drain -> P2 is not captured until ST_IDLE. P2's first word appears exactly 2 cycles after P1's last transfer.
- Assert rst for 1 cycle after word 5 transfers -> out_valid=0 and busy=0 the next cycle. A new prod=0xABCD then streams from idx0 with data 0xABCD.
- With SBM_UNLOAD_MSW_FIRST_EN defined, prod=2^1141 -> first word idx17 = 0x0020_0000_0000_0000, then idx16..0 = 0. out_last at idx0.
